// File: rtl/elastic_pipe_reg.sv
// Elastic pipeline register: valid/ready boundary with a main (head) entry and one skid entry.
// Optional stall/bubble performance counters are built when ELASTIC_PIPE_PERF_EN is defined.
module elastic_pipe_reg #(
    parameter int                DATA_W   = 32,
    parameter int                CTRL_W   = 24,
    parameter logic [CTRL_W-1:0] NOP_CTRL = '0,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef ELASTIC_PIPE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state_reg,     state_next;
    logic [DATA_W-1:0] main_data_reg, main_data_next;
    logic [CTRL_W-1:0] main_ctrl_reg, main_ctrl_next;
    logic [DATA_W-1:0] skid_data_reg, skid_data_next;
    logic [CTRL_W-1:0] skid_ctrl_reg, skid_ctrl_next;
    logic              in_ready_reg,  in_ready_next;

    logic in_fire;
    logic out_fire;
    logic main_valid;

    assign main_valid = (state_reg != ST_EMPTY);
    assign in_fire    = in_valid & in_ready_reg;
    assign out_fire   = main_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_EMPTY;
            main_data_reg <= '0;
            main_ctrl_reg <= '0;
            skid_data_reg <= '0;
            skid_ctrl_reg <= '0;
            in_ready_reg  <= 1'b1;
        end else begin
            state_reg     <= state_next;
            main_data_reg <= main_data_next;
            main_ctrl_reg <= main_ctrl_next;
            skid_data_reg <= skid_data_next;
            skid_ctrl_reg <= skid_ctrl_next;
            in_ready_reg  <= in_ready_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        main_data_next = main_data_reg;
        main_ctrl_next = main_ctrl_reg;
        skid_data_next = skid_data_reg;
        skid_ctrl_next = skid_ctrl_reg;

        if (flush) begin
            // Only the valid state is killed; stale payload is harmless.
            state_next = ST_EMPTY;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_data_next = in_data;
                        main_ctrl_next = in_ctrl;
                        state_next     = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && !out_fire) begin
                        skid_data_next = in_data;
                        skid_ctrl_next = in_ctrl;
                        state_next     = ST_FULL;
                    end else if (in_fire && out_fire) begin
                        main_data_next = in_data;
                        main_ctrl_next = in_ctrl;
                    end else if (out_fire) begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so no new entry can arrive.
                    if (out_fire) begin
                        main_data_next = skid_data_reg;
                        main_ctrl_next = skid_ctrl_reg;
                        state_next     = ST_ONE;
                    end
                end
                default: begin
                    state_next = ST_EMPTY;
                end
            endcase
        end
    end

    // Registered ready: skid is free in every state except FULL.
    assign in_ready_next = (state_next != ST_FULL);

    assign in_ready  = in_ready_reg;
    assign out_valid = main_valid;
    assign out_data  = main_data_reg;
    assign out_ctrl  = main_valid ? main_ctrl_reg : NOP_CTRL;

`ifdef ELASTIC_PIPE_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0] perf_hit;
    assign perf_hit[0] = main_valid & ~out_ready;
    assign perf_hit[1] = ~main_valid;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_perf
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (perf_hit[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_reg <= cnt_reg + CNT_ONE;
                end
            end
        end
    endgenerate

    assign stall_cnt  = g_perf[0].cnt_reg;
    assign bubble_cnt = g_perf[1].cnt_reg;
`endif

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Randomized + directed scoreboard bench for elastic_pipe_reg; the reference is a 2-deep FIFO queue.
// Perf-counter checks are compiled in when ELASTIC_PIPE_PERF_EN is defined.
module tb_elastic_pipe_reg;

    localparam int             DW   = 32;
    localparam int             CW   = 24;
    localparam int             CNTW = 4;
    localparam logic [CW-1:0]  NOP  = 24'h00C0DE;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
`ifdef ELASTIC_PIPE_PERF_EN
    logic [CNTW-1:0] stall_cnt;
    logic [CNTW-1:0] bubble_cnt;
`endif

    elastic_pipe_reg #(
        .DATA_W(DW), .CTRL_W(CW), .NOP_CTRL(NOP), .CNT_W(CNTW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl)
`ifdef ELASTIC_PIPE_PERF_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    ent_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   stall_m = 0;
    int   bubble_m = 0;
    int   occ0 = 0;
    localparam int CNT_MAX = (1 << CNTW) - 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    // One upstream/downstream action per rising edge; model updated once the cycle's in_ready is known.
    task automatic cycle(input bit iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input bit ordy, input bit fl, output bit fired);
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        occ0      = exp_q.size();
        #2;
        fired = iv && in_ready;
        if (rst_n) begin
            if (occ0 > 0 && !ordy && stall_m < CNT_MAX) stall_m++;
            if (occ0 == 0 && bubble_m < CNT_MAX) bubble_m++;
            if (fl) exp_q.delete();
            else if (fired) exp_q.push_back('{d: d, c: c});
        end
    endtask

    // Monitor: compares outputs to the model head and retires entries on a downstream accept.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            chk("out_valid", out_valid, exp_q.size() > 0);
            chk("in_ready", in_ready, exp_q.size() < 2);
            if (exp_q.size() > 0) begin
                chk("out_data", out_data, exp_q[0].d);
                chk("out_ctrl", out_ctrl, exp_q[0].c);
                if (out_ready) void'(exp_q.pop_front());
            end else begin
                chk("out_ctrl_nop", out_ctrl, NOP);
            end
`ifdef ELASTIC_PIPE_PERF_EN
            chk("stall_cnt", stall_cnt, stall_m);
            chk("bubble_cnt", bubble_cnt, bubble_m);
`endif
        end
    end

    initial begin
        bit f;
        bit pend;
        bit iv;
        bit ordy;
        bit fl;
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        int n;
        int b0;

        // Power-on reset, released between edges so the next cycle() covers the first edge.
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // T2: back-to-back stream 1..8
        for (int i = 1; i <= 8; i++) cycle(1, i, CW'(i * 3), 1, 0, f);
        cycle(0, 0, 0, 1, 0, f);
        cycle(0, 0, 0, 1, 0, f);

        // T3: backpressure, C held by source until accepted
        cycle(1, 32'hA, 24'h1A, 0, 0, f);
        cycle(1, 32'hB, 24'h1B, 0, 0, f);
        n = 0;
        f = 0;
        while (!f && n < 10) begin
            cycle(1, 32'hC, 24'h1C, (n > 0), 0, f);
            n++;
        end
        chk("t3_c_accepted", f, 1'b1);
        repeat (3) cycle(0, 0, 0, 1, 0, f);

        // T4: flush while FULL with D offered
        cycle(1, 32'h11, 24'h2A, 0, 0, f);
        cycle(1, 32'h22, 24'h2B, 0, 0, f);
        cycle(1, 32'hD, 24'h2D, 0, 1, f);
        cycle(0, 0, 0, 1, 0, f);
        chk("t4_in_ready", in_ready, 1'b1);
        chk("t4_out_valid", out_valid, 1'b0);
        repeat (2) cycle(0, 0, 0, 1, 0, f);

        // T5: ONE with simultaneous in/out fire
        cycle(1, 32'h51, 24'h3A, 1, 0, f);
        cycle(1, 32'h52, 24'h3B, 1, 0, f);
        cycle(1, 32'h53, 24'h3C, 1, 0, f);
        cycle(0, 0, 0, 0, 0, f);
        chk("t5_out_data", out_data, 32'h53);
        chk("t5_in_ready", in_ready, 1'b1);
        cycle(0, 0, 0, 1, 0, f);
        cycle(0, 0, 0, 1, 0, f);

        // Randomized traffic with upstream hold rule
        pend = 0;
        d = '0;
        c = '0;
        for (int i = 0; i < 800; i++) begin
            if (!pend) begin
                iv = ($urandom_range(0, 9) < 7);
                d  = $urandom;
                c  = CW'($urandom);
            end else begin
                iv = 1;
            end
            ordy = (i % 200 < 40) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 7);
            fl   = ($urandom_range(0, 29) == 0);
            cycle(iv, d, c, ordy, fl, f);
            pend = iv && !f;
        end
        cycle(0, 0, 0, 1, 0, f);
        cycle(0, 0, 0, 1, 0, f);

        // T1: fill to FULL, then async reset mid-cycle
        cycle(1, 32'hAAAA, 24'h4A, 0, 0, f);
        cycle(1, 32'hBBBB, 24'h4B, 0, 0, f);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t1_out_valid", out_valid, 1'b0);
        chk("t1_in_ready", in_ready, 1'b1);
        chk("t1_out_ctrl", out_ctrl, NOP);
        chk("t1_out_data", out_data, '0);
        exp_q.delete();
        stall_m  = 0;
        bubble_m = 0;
        in_valid = 1'b1;
        in_data  = 32'hEEEE;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        in_valid = 1'b0;
        #1 rst_n = 1'b1;
        repeat (3) cycle(0, 0, 0, 1, 0, f);
        chk("t1_no_ab", out_valid, 1'b0);

`ifdef ELASTIC_PIPE_PERF_EN
        // T6: counter saturation, flush leaves counters alone, idle bubbles
        cycle(1, 32'h66, 24'h6A, 0, 0, f);
        repeat (20) cycle(0, 0, 0, 0, 0, f);
        cycle(0, 0, 0, 0, 0, f);
        chk("t6_stall_sat", stall_cnt, 4'hF);
        cycle(0, 0, 0, 0, 1, f);
        cycle(0, 0, 0, 1, 0, f);
        chk("t6_stall_after_flush", stall_cnt, 4'hF);
        b0 = bubble_m;
        repeat (3) cycle(0, 0, 0, 1, 0, f);
        chk("t6_bubble_plus3", bubble_cnt, (b0 + 3 > CNT_MAX) ? CNT_MAX : b0 + 3);
`else
        b0 = 0;
`endif
        cycle(0, 0, 0, 1, 0, f);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
